// File: rtl/ghostbox_pkg.sv
// Shared GhostBox types and constants: scheduler state encoding, LFSR taps and seed.
package ghostbox_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PULSE = ST_PULSE,
    GAP   = ST_GAP
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Number of gap base units for a level: 16 at level 0 down to 1 at level 15.
  function automatic logic [31:0] gap_units(input logic [3:0] level);
    return 32'(5'd16 - {1'b0, level});
  endfunction

endpackage

// File: rtl/click_lfsr.sv
// Free-running 16-bit Galois LFSR (right shift) used to jitter the click gaps.
module click_lfsr
  import ghostbox_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_state
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  // Each bit takes its upper neighbour, XORed with the shifted-out bit where a tap sits.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_tap
      assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
    end
  endgenerate
  assign lfsr_next[15] = LFSR_TAPS[15] & lfsr_reg[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign o_state = lfsr_reg;

endmodule

// File: rtl/click_scheduler.sv
// Click sequencer: turns an activity level into jittered periodic click pulses,
// plus one-shot triggered clicks, with a wrapping count of clicks started.
module click_scheduler
  import ghostbox_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 30000,
  parameter int unsigned GAP_SHIFT    = 20,
  parameter logic [15:0] JITTER_MASK  = 16'h3FFF,
  parameter logic [15:0] LFSR_SEED    = LFSR_DEFAULT_SEED
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [3:0] i_level,
  input  logic       i_trig,
  output logic       o_click,
  output logic       o_busy,
  output logic [7:0] o_click_cnt
);

  localparam logic [31:0] PULSE_LOAD = 32'(PULSE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        click_reg, click_next;
  logic [7:0]  click_cnt_reg, click_cnt_next;
  logic [15:0] lfsr_state;
  logic        periodic;
  logic        start_pulse;
  logic [31:0] gap_len;

  click_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_state(lfsr_state)
  );

  assign periodic = i_enable && (i_level != 4'd0);
  assign gap_len  = (gap_units(i_level) << GAP_SHIFT) + {16'd0, lfsr_state & JITTER_MASK};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    click_next     = click_reg;
    click_cnt_next = click_cnt_reg;
    start_pulse    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_trig || periodic) start_pulse = 1'b1;
      end
      PULSE: begin
        // Triggers are deliberately ignored here; a pulse always runs full width.
        if (cnt_reg == 32'd0) begin
          click_next = 1'b0;
          if (periodic) begin
            state_next = GAP;
            cnt_next   = gap_len;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      GAP: begin
        // Trigger beats a simultaneous disable.
        if (i_trig) begin
          start_pulse = 1'b1;
        end else if (!periodic) begin
          state_next = IDLE;
        end else if (cnt_reg == 32'd0) begin
          start_pulse = 1'b1;
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      default: begin
        state_next = IDLE;
        click_next = 1'b0;
      end
    endcase

    if (start_pulse) begin
      state_next     = PULSE;
      click_next     = 1'b1;
      cnt_next       = PULSE_LOAD;
      click_cnt_next = click_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 32'd0;
      click_reg     <= 1'b0;
      click_cnt_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      click_reg     <= click_next;
      click_cnt_reg <= click_cnt_next;
    end
  end

  assign o_click     = click_reg;
  assign o_busy      = (state_reg != IDLE);
  assign o_click_cnt = click_cnt_reg;

endmodule

// File: tb/tb_click_scheduler.sv
// Directed bench for click_scheduler with short pulses/gaps; one jittered instance for gap-length checks.
module tb_click_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, enable, trig;
  logic [3:0] level;
  logic       click, busy;
  logic [7:0] click_cnt;

  logic       rst_n_j, enable_j, trig_j;
  logic [3:0] level_j;
  logic       click_j, busy_j;
  logic [7:0] click_cnt_j;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  click_scheduler #(
    .PULSE_CYCLES(4), .GAP_SHIFT(2), .JITTER_MASK(16'h0000), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_level(level), .i_trig(trig),
    .o_click(click), .o_busy(busy), .o_click_cnt(click_cnt)
  );

  click_scheduler #(
    .PULSE_CYCLES(4), .GAP_SHIFT(2), .JITTER_MASK(16'h00FF), .LFSR_SEED(16'hACE1)
  ) dut_j (
    .i_clk(clk), .i_rst_n(rst_n_j), .i_enable(enable_j), .i_level(level_j), .i_trig(trig_j),
    .o_click(click_j), .o_busy(busy_j), .o_click_cnt(click_cnt_j)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    if (s[0]) return (s >> 1) ^ 16'hB400;
    return s >> 1;
  endfunction

  initial begin
    logic [15:0] ref_lfsr, pre;
    logic        prev_click, in_gap;
    int          n_rise, low_run, exp_low, cyc;
    logic [7:0]  exp_cnt8;

    rst_n = 1'b0; enable = 1'b1; level = 4'd15; trig = 1'b0;
    rst_n_j = 1'b0; enable_j = 1'b1; level_j = 4'd15; trig_j = 1'b0;

    // Reset held with a qualifying input
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_click", 32'(click), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(click_cnt), 32'd0);
    end
    rst_n = 1'b1;

    // Periodic at level 15: 4 high, 5 low
    for (int k = 1; k <= 28; k++) begin
      tick();
      chk($sformatf("per_click_k%0d", k), 32'(click), 32'(((k - 1) % 9) < 4));
      chk($sformatf("per_cnt_k%0d", k), 32'(click_cnt), 32'((k - 1) / 9 + 1));
      chk($sformatf("per_busy_k%0d", k), 32'(busy), 32'd1);
    end

    // Asynchronous reset mid-click
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_click", 32'(click), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cnt", 32'(click_cnt), 32'd0);

    // Level 0 then single trigger
    level = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("lvl0_idle_click", 32'(click), 32'd0);
    chk("lvl0_idle_busy", 32'(busy), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      trig = (k == 1);
      tick();
      trig = 1'b0;
      chk($sformatf("trig_click_k%0d", k), 32'(click), 32'(k <= 4));
      chk($sformatf("trig_busy_k%0d", k), 32'(busy), 32'(k <= 4));
      chk($sformatf("trig_cnt_k%0d", k), 32'(click_cnt), 32'd1);
    end

    // Trigger during a pulse is ignored
    for (int k = 1; k <= 6; k++) begin
      trig = (k == 1 || k == 3);
      tick();
      trig = 1'b0;
      chk($sformatf("ign_click_k%0d", k), 32'(click), 32'(k <= 4));
      chk($sformatf("ign_cnt_k%0d", k), 32'(click_cnt), 32'd2);
    end

    // Level 1 -> 15 mid-gap: current gap stays 60, next gap is 4
    rst_n = 1'b0; level = 4'd1; enable = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 11) level = 4'd15;
      tick();
      chk($sformatf("lvl_click_k%0d", k), 32'(click),
          32'((k <= 4) || (k >= 66 && k <= 69) || (k >= 75 && k <= 78)));
    end
    chk("lvl_cnt", 32'(click_cnt), 32'd3);

    // Trigger and disable on the same gap cycle: trigger wins
    trig = 1'b1; enable = 1'b0;
    tick();
    trig = 1'b0;
    chk("win_click", 32'(click), 32'd1);
    chk("win_cnt", 32'(click_cnt), 32'd4);
    for (int k = 2; k <= 5; k++) tick();
    chk("win_end_click", 32'(click), 32'd0);
    chk("win_end_busy", 32'(busy), 32'd0);

    // Jittered gaps against a reference LFSR, 256 clicks with count wrap
    rst_n_j = 1'b1;
    ref_lfsr = 16'hACE1;
    prev_click = 1'b0; in_gap = 1'b0;
    n_rise = 0; low_run = 0; exp_low = 0; cyc = 0;
    while (n_rise < 256 && cyc < 90000) begin
      pre = ref_lfsr;
      tick();
      ref_lfsr = ref_step(ref_lfsr);
      cyc++;
      if (click_j && !prev_click) begin
        n_rise++;
        exp_cnt8 = 8'(n_rise);
        chk($sformatf("jit_cnt_n%0d", n_rise), 32'(click_cnt_j), 32'(exp_cnt8));
        if (in_gap) chk($sformatf("jit_gap_n%0d", n_rise), 32'(low_run), 32'(exp_low));
        in_gap = 1'b0;
      end else if (!click_j && prev_click) begin
        exp_low = (1 << 2) + int'(pre & 16'h00FF) + 1;
        low_run = 1;
        in_gap  = 1'b1;
      end else if (!click_j) begin
        low_run++;
      end
      prev_click = click_j;
    end
    chk("jit_rises", 32'(n_rise), 32'd256);
    chk("jit_wrap", 32'(click_cnt_j), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/click_scheduler.md
# click_scheduler

Sequencer for the GhostBox clicking-noise output. It converts a 4-bit activity level into a stream of fixed-width click pulses. Gaps between clicks shrink as the level rises, with LFSR jitter so the clicking sounds irregular. It also accepts one-shot click requests. It sits between the ghost-detection logic, which drives the level and triggers, and the speaker/LED output pin.

## Interface
- PULSE_CYCLES, 30000: click high time in clock cycles; must be ≥1.
- GAP_SHIFT, 20: gap base unit is 2^GAP_SHIFT cycles.
- JITTER_MASK, 16'h3FFF: mask applied to the LFSR to form the random gap extension.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_enable  input  1  enables periodic clicking.
- i_level  input  4  activity level; 0 = no periodic clicks, 15 = densest.
- i_trig  input  1  single-cycle request for one immediate click.
- o_click  output  1  click drive, registered.
- o_busy  output  1  high while in PULSE or GAP.
- o_click_cnt  output  8  count of clicks started; wraps at 255→0.

## Operation
- Reset values: state IDLE; o_click=0; o_busy=0; o_click_cnt=0; pulse/gap counter=0; LFSR=LFSR_SEED.
- LFSR: 16-bit Galois type with taps 16'hB400, shifting right every cycle out of reset. It never reaches 0.
- States: IDLE, PULSE, GAP.
- IDLE:
  - Go to PULSE when i_trig=1, or when i_enable=1 and i_level≠0.
  - o_click=0.
- PULSE:
  - o_click=1 for exactly PULSE_CYCLES cycles.
  - Then leave PULSE:
    - to GAP if i_enable=1 and i_level≠0;
    - to IDLE otherwise.
  - i_trig is ignored in PULSE; there is no queueing.
- GAP entry:
  - Latch gap length G = ((16 − i_level) << GAP_SHIFT) + (LFSR & JITTER_MASK).
  - i_level and LFSR are sampled on the cycle of entry.
  - Arithmetic is 32-bit unsigned and cannot overflow with legal parameters (GAP_SHIFT ≤ 27).
- GAP:
  - o_click=0; count G cycles, then go to PULSE.
  - A later change to i_level does not alter the current G.
  - i_trig=1 aborts the gap and goes to PULSE next cycle.
  - i_enable=0 or i_level=0 during GAP goes to IDLE next cycle.
  - If i_trig and a disable arrive on the same cycle, i_trig wins and goes to PULSE.
- o_click_cnt increments by 1 on every entry to PULSE, including trigger-initiated clicks.
- o_busy = (state ≠ IDLE).

## Timing
- If the PULSE-entry condition is sampled at clock edge N, o_click is high from edge N+1 through edge N+PULSE_CYCLES, and low after edge N+PULSE_CYCLES+1.
- o_click_cnt updates at edge N+1, together with the o_click rise.
- Periodic click period = PULSE_CYCLES + G + 1 cycles.
  - The extra cycle is the PULSE→GAP latch cycle.
  - GAP→PULSE is counted inside G.
- Trigger latency: 1 cycle from IDLE or GAP.
- Reset assertion mid-click forces o_click=0 immediately (asynchronous). No partial pulse resumes after release.
- First click after reset release needs a qualifying input sampled on the first active edge.

## Structure
- Shared package ghostbox_pkg:
  - state enum (IDLE/PULSE/GAP);
  - LFSR tap constant 16'hB400;
  - default seed.
- One sub-module, click_lfsr: free-running 16-bit Galois LFSR with parameterised seed and output state.
- The FSM, the 32-bit down-counter and the click counter live in click_scheduler.

## Test plan
All scenarios use PULSE_CYCLES=4, GAP_SHIFT=2, JITTER_MASK=0.
- Reset: hold i_rst_n=0 with i_enable=1 and i_level=15 → o_click=0, o_busy=0, o_click_cnt=0 throughout. After release, the first o_click rise comes 1 cycle later.
- Periodic, level 15: G=4 → o_click high 4 cycles, low 5 cycles, repeating. o_click_cnt counts 1,2,3,…
- Level 0 with i_enable=1, then a single-cycle i_trig → exactly one 4-cycle pulse, then IDLE. o_click_cnt=1.
- i_trig during PULSE → pulse width is still 4 cycles. o_click_cnt rises by 1, not 2.
- i_level 1 to 15 mid-GAP (G=60) → the current gap is still 60 cycles; the next gap is 4 cycles.
- Jitter: JITTER_MASK=16'h00FF, seed 16'hACE1 → each G matches a reference-model LFSR sampled at GAP entry. Run 256 clicks with no repeat-stuck and the LFSR never 0. Also force o_click_cnt from 255 to wrap to 0.
